fifo_fwft_ctrl: RTL
===================

# fifo_fwft_ctrl

First-word-fall-through FIFO controller that drives the team's simple dual-port RAM (`mem` with `waddr`/`write_data`/`write_en` and `raddr`/`read_data`, 1-cycle registered read). It owns the write and read pointers and full/empty accounting. A 2-deep output stage hides the RAM's read latency, so a consumer sees the head word on `dout` whenever `empty` is low, and can pop once per cycle at full throughput. The RAM is instantiated beside this block with `wclk` and `rclk` both tied to `clk`.

## Interface
- `WIDTH`, 8, word width; must match RAM `SIZE`
- `ENTRIES`, 16, RAM depth; must match RAM `DEPTH`; power of 2, ≥2
- `clk` in 1 — single clock; also drives both RAM clocks
- `rst` in 1 — synchronous, active-high reset
- `din` in WIDTH — write data
- `wput` in 1 — write request; accepted when `full`=0
- `full` out 1 — RAM region holds ENTRIES words
- `dout` out WIDTH — head-of-queue word; valid when `empty`=0
- `rget` in 1 — pop request; accepted when `empty`=0
- `empty` out 1 — no word on `dout`
- `count` out $clog2(ENTRIES)+2 — total words held
- `ram_waddr` out $clog2(ENTRIES) — to RAM `waddr`
- `ram_wdata` out WIDTH — to RAM `write_data`
- `ram_we` out 1 — to RAM `write_en`
- `ram_raddr` out $clog2(ENTRIES) — to RAM `raddr`
- `ram_rdata` in WIDTH — from RAM `read_data`

## Operation
- **Pointers.** `wptr` and `rptr` are $clog2(ENTRIES)+1 bits; the MSB is the wrap bit and the low bits address the RAM. Both wrap modulo 2·ENTRIES.
- **RAM occupancy.** `used = wptr - rptr`, modulo arithmetic.
- **`full`.** `full = (used == ENTRIES)`.
- **Write path.**
  - `ram_we = wput & ~full`, combinational.
  - `ram_waddr = wptr[low]` and `ram_wdata = din`.
  - `wptr` increments on each accepted write.
  - `wput` while `full` is ignored, with no state change.
- **Output stage.**
  - Registers: `dout_r`/`dout_v` (head), `skid_r`/`skid_v` (second), and `pend` (a read is in flight in the RAM).
  - `O = dout_v + skid_v + pend`; invariant O ≤ 2.
  - `pop = rget & dout_v`.
- **Read issue.**
  - Issue when `used != 0` and `O - pop ≤ 1`.
  - On issue: `rptr` increments and `pend` is set next cycle; otherwise `pend` is cleared.
  - `ram_raddr = rptr[low]` is driven every cycle; reads without an issue are ignored.
- **Landing** (`pend`=1, `ram_rdata` valid this cycle):
  - If `dout_v` is 0, or `pop` with `skid_v`=0, the data goes to `dout_r`.
  - Otherwise it goes to `skid_r`.
- **Pop.**
  - If `skid_v`=1, `skid_r` moves to `dout_r`.
  - Else if landing, the landing data goes to `dout_r`.
  - Else `dout_v` clears.
  - Order is strictly preserved: `dout_r` is older than `skid_r`, which is older than in-flight data.
- **Status outputs.**
  - `empty = ~dout_v`.
  - `count = used + dout_v + skid_v + pend`; maximum is ENTRIES+2.
  - `full`, `empty` and `count` depend on registers only; there is no combinational path from `wput`/`rget`.
- **RAM hazard.** The RAM write and read addresses never collide: a read issues only for `rptr != wptr`, and a write at `wptr[low] == rptr[low]` occurs only when `full`, which is blocked.
- **Simultaneous events.** A write and a pop in the same cycle are both honoured. A write into an empty FIFO is not visible to the read-issue logic until the next cycle.
- **Reset.**
  - On `rst`: pointers, `pend`, `dout_v`, `skid_v` and `dout_r` clear to 0.
  - Outputs after reset: `empty`=1, `full`=0, `count`=0, `dout`=0, `ram_we`=0 (given `wput` is ignored during reset).
  - A read in flight when reset is applied is discarded.

## Timing
- **Write-to-visible latency:** 3 cycles.
  - Edge k samples `wput`.
  - Cycle k+1: the read issues.
  - Cycle k+2: `ram_rdata` is valid.
  - After edge k+3: `empty`=0 and `dout` = the word.
- **Throughput:** one write per cycle and one pop per cycle, sustained. Under continuous push and pop at steady state, `empty` never toggles.
- **`full`** asserts the cycle after the ENTRIES-th unread RAM write. It deasserts the cycle after the read issue that frees a slot.
- **Signal timing:** `dout` and `empty` are registered. `ram_we`, `ram_waddr`, `ram_wdata` and `ram_raddr` are combinational from `wput`, `din` and the registers.

## Configuration
- Macro: `FIFO_FWFT_CTRL_ERRS_EN`.
- **Defined:** adds outputs `overflow` (1) and `underflow` (1).
  - `overflow` is sticky and sets on `wput & full`.
  - `underflow` is sticky and sets on `rget & empty`.
  - Both clear only on `rst`, and reset to 0.
- **Undefined:** the two ports and their logic do not exist. Illegal requests are silently ignored.

## Test plan
- **Reset:** assert `rst` with `wput`/`rget` high → `empty`=1, `full`=0, `count`=0, `dout`=0, `ram_we`=0 throughout.
- **Single word:** write 0xA5 once → `dout`=0xA5 and `empty`=0 exactly 3 cycles after the write edge. Pop → `empty`=1 next cycle and `count`=0.
- **Fill:** ENTRIES=16, write 0..19 without popping → `full`=1 once 18 words are held (16 in RAM + 2 in output stage) and `count`=18. Writes 18 and 19 are ignored. Draining yields 0..17 in order.
- **Streaming:** continuous `wput` and `rget` for 100 cycles with an incrementing pattern → output in order, no gaps after the first word, `empty` stays low, and `count` is steady.
- **Random stall:** random `rget` at 30% with random `wput` at 70% over 10k cycles → the scoreboard matches, O ≤ 2 always, and the RAM read/write addresses never collide.
- **Errors (`FIFO_FWFT_CTRL_ERRS_EN`):** `rget` on empty → `underflow`=1. `wput` while `full` → `overflow`=1. Both stay set until `rst`.

Source files
------------

// File: rtl/fifo_fwft_ctrl_if.sv
// fifo_fwft_ctrl_if: producer/consumer handshake plus RAM-side signals for fifo_fwft_ctrl.
// Optional error flags (overflow/underflow) exist only when FIFO_FWFT_CTRL_ERRS_EN is defined.
`timescale 1ns/1ps
interface fifo_fwft_ctrl_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ENTRIES = 16
);
    localparam int unsigned AW = $clog2(ENTRIES);
    localparam int unsigned CW = AW + 2;

    logic [WIDTH-1:0] din;
    logic             wput;
    logic             full;
    logic [WIDTH-1:0] dout;
    logic             rget;
    logic             empty;
    logic [CW-1:0]    count;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_we;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
`ifdef FIFO_FWFT_CTRL_ERRS_EN
    logic             overflow;
    logic             underflow;

    modport slave (
        input  din, wput, rget, ram_rdata,
        output full, dout, empty, count, ram_waddr, ram_wdata, ram_we, ram_raddr,
        output overflow, underflow
    );
    modport master (
        output din, wput, rget, ram_rdata,
        input  full, dout, empty, count, ram_waddr, ram_wdata, ram_we, ram_raddr,
        input  overflow, underflow
    );
`else
    modport slave (
        input  din, wput, rget, ram_rdata,
        output full, dout, empty, count, ram_waddr, ram_wdata, ram_we, ram_raddr
    );
    modport master (
        output din, wput, rget, ram_rdata,
        input  full, dout, empty, count, ram_waddr, ram_wdata, ram_we, ram_raddr
    );
`endif
endinterface

// File: rtl/fifo_fwft_ctrl.sv
// fifo_fwft_ctrl: first-word-fall-through controller around a 1-cycle registered-read RAM.
// A 2-deep output stage (head + skid) plus one in-flight read hides the RAM latency.
// Optional macro FIFO_FWFT_CTRL_ERRS_EN adds sticky overflow/underflow flags.
`timescale 1ns/1ps
module fifo_fwft_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ENTRIES = 16
) (
    input logic              clk,
    input logic              rst,
    fifo_fwft_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(ENTRIES);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = AW + 2;

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    used;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] skid_r;
    logic             dout_v;
    logic             skid_v;
    logic             pend;
    logic             full_i;
    logic             wr;
    logic             pop;
    logic             issue;
    logic             land_head;
    logic             land_skid;
    logic [1:0]       occ;

    // Occupancy and request qualification; all status comes from registers only.
    assign used      = wptr - rptr;
    assign full_i    = (used == PW'(ENTRIES));
    assign wr        = bus.wput & ~full_i & ~rst;
    assign pop       = bus.rget & dout_v;
    assign occ       = 2'(dout_v) + 2'(skid_v) + 2'(pend);
    // Keep at most two words in stage + flight after this cycle's pop.
    assign issue     = (used != '0) && (occ <= (2'(pop) + 2'd1));
    // Landing word goes to the head when the head is free or is being refilled by nothing older.
    assign land_head = pend & (~dout_v | (pop & ~skid_v));
    assign land_skid = pend & ~land_head;

    // Pointers, in-flight flag and output-stage valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            pend   <= 1'b0;
            dout_v <= 1'b0;
            skid_v <= 1'b0;
            dout_r <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + PW'(1);
            end
            if (issue) begin
                rptr <= rptr + PW'(1);
            end
            pend <= issue;
            if (pop && skid_v) begin
                dout_r <= skid_r;
            end else if (land_head) begin
                dout_r <= bus.ram_rdata;
            end
            if (land_head || (pop && skid_v)) begin
                dout_v <= 1'b1;
            end else if (pop) begin
                dout_v <= 1'b0;
            end
            if (land_skid) begin
                skid_v <= 1'b1;
            end else if (pop) begin
                skid_v <= 1'b0;
            end
        end
    end

    // Skid data needs no reset; it is qualified by skid_v.
    always_ff @(posedge clk) begin
        if (land_skid) begin
            skid_r <= bus.ram_rdata;
        end
    end

`ifdef FIFO_FWFT_CTRL_ERRS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky illegal-request flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.wput && full_i) begin
                overflow_r <= 1'b1;
            end
            if (bus.rget && !dout_v) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
`endif

    assign bus.full      = full_i;
    assign bus.empty     = ~dout_v;
    assign bus.dout      = dout_r;
    assign bus.count     = CW'(used) + CW'(dout_v) + CW'(skid_v) + CW'(pend);
    assign bus.ram_we    = wr;
    assign bus.ram_waddr = wptr[AW-1:0];
    assign bus.ram_wdata = bus.din;
    assign bus.ram_raddr = rptr[AW-1:0];

endmodule
